// File: rtl/demux_load_scheduler.sv
// Sequencer/arbiter that owns the 10-register write demux: runs NREG-byte burst loads from a source
// port and interleaves single user writes, parking the selector on a scratch code whenever idle.
module demux_load_scheduler #(
  parameter int unsigned   NREG     = 9,
  parameter int unsigned   DW       = 8,
  parameter int unsigned   SW       = 4,
  parameter logic [SW-1:0] PARK_SEL = SW'(9),
  parameter int unsigned   TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          burst_start,
  output logic          rd_req,
  output logic [SW-1:0] rd_addr,
  input  logic          rd_valid,
  input  logic [DW-1:0] rd_data,
  input  logic          wr_req,
  input  logic [SW-1:0] wr_sel,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic [SW-1:0] selector,
  output logic [DW-1:0] dato,
  output logic          busy,
  output logic          burst_done,
  output logic          err_timeout
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_SINGLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [SW-1:0] LAST_IDX = SW'(NREG - 1);
  localparam logic [SW-1:0] SCRATCH  = SW'(NREG);
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  logic [2:0]    state, state_d;
  logic          pending, pending_d;
  logic          in_burst, in_burst_d;
  logic [TW-1:0] cnt, cnt_d;
  logic          rd_req_d, wr_ack_d, busy_d, burst_done_d, err_timeout_d;
  logic [SW-1:0] rd_addr_d, selector_d;
  logic [DW-1:0] dato_d;
  logic          go_single, go_beat;

  // Next-state and next-output logic; outputs describe the cycle entered at the next edge
  always_comb begin
    state_d       = state;
    pending_d     = pending;
    in_burst_d    = in_burst;
    cnt_d         = cnt;
    rd_addr_d     = rd_addr;
    rd_req_d      = 1'b0;
    selector_d    = PARK_SEL;
    dato_d        = '0;
    wr_ack_d      = 1'b0;
    burst_done_d  = 1'b0;
    err_timeout_d = 1'b0;
    go_single     = 1'b0;
    go_beat       = 1'b0;

    // One-deep burst request memory for starts that cannot be served immediately
    if (burst_start && ((state != S_IDLE) || wr_req)) pending_d = 1'b1;

    case (state)
      S_IDLE: begin
        if (wr_req) begin
          go_single = 1'b1;
        end else if (burst_start || pending) begin
          state_d    = S_FETCH;
          rd_addr_d  = '0;
          rd_req_d   = 1'b1;
          cnt_d      = '0;
          in_burst_d = 1'b1;
        end
      end
      S_FETCH: begin
        if (rd_valid) begin
          state_d    = S_WRITE;
          selector_d = rd_addr;
          dato_d     = rd_data;
        end else if (cnt == CNT_LAST) begin
          state_d       = S_IDLE;
          err_timeout_d = 1'b1;
          pending_d     = 1'b0;
          in_burst_d    = 1'b0;
        end else begin
          cnt_d    = cnt + TW'(1);
          rd_req_d = 1'b1;
        end
      end
      S_WRITE: begin
        if (wr_req) go_single = 1'b1;
        else        go_beat   = 1'b1;
      end
      S_SINGLE: begin
        // Never chain two singles: a held wr_req waits for the next burst beat
        if (in_burst) go_beat = 1'b1;
        else          state_d = S_IDLE;
      end
      S_DONE: begin
        state_d   = S_IDLE;
        pending_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (go_single) begin
      state_d  = S_SINGLE;
      wr_ack_d = 1'b1;
      if (wr_sel <= SCRATCH) begin
        selector_d = wr_sel;
        dato_d     = wr_data;
      end
    end

    if (go_beat) begin
      if (rd_addr < LAST_IDX) begin
        state_d   = S_FETCH;
        rd_addr_d = rd_addr + SW'(1);
        rd_req_d  = 1'b1;
        cnt_d     = '0;
      end else begin
        state_d      = S_DONE;
        burst_done_d = 1'b1;
        in_burst_d   = 1'b0;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      pending     <= 1'b0;
      in_burst    <= 1'b0;
      cnt         <= '0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      wr_ack      <= 1'b0;
      selector    <= PARK_SEL;
      dato        <= '0;
      busy        <= 1'b0;
      burst_done  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      pending     <= pending_d;
      in_burst    <= in_burst_d;
      cnt         <= cnt_d;
      rd_req      <= rd_req_d;
      rd_addr     <= rd_addr_d;
      wr_ack      <= wr_ack_d;
      selector    <= selector_d;
      dato        <= dato_d;
      busy        <= busy_d;
      burst_done  <= burst_done_d;
      err_timeout <= err_timeout_d;
    end
  end

endmodule

// File: tb/tb_demux_load_scheduler.sv
// Bench for demux_load_scheduler: random source data/latency, a demux register model and
// expected write lists built from the load/priority rules.
module tb_demux_load_scheduler;
  localparam int unsigned NREG = 9;
  localparam logic [3:0]  PARK = 4'd9;

  logic       clk, reset, burst_start, rd_req, rd_valid, wr_req, wr_ack;
  logic       busy, burst_done, err_timeout;
  logic [3:0] rd_addr, wr_sel, selector;
  logic [7:0] rd_data, wr_data, dato;

  demux_load_scheduler #(.NREG(9), .DW(8), .SW(4), .PARK_SEL(4'd9), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .burst_start(burst_start),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_sel(wr_sel), .wr_data(wr_data), .wr_ack(wr_ack),
    .selector(selector), .dato(dato), .busy(busy),
    .burst_done(burst_done), .err_timeout(err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  logic [7:0]  src_data [16];
  int          src_lat;
  logic [3:0]  src_hang;
  logic [7:0]  demux [10];
  logic [7:0]  exp_regs [NREG];
  logic [11:0] wq [$];
  logic [11:0] exp_q [$];
  int          n_done = 0, n_ack = 0, n_to = 0, adjacent = 0, park_bad = 0;
  int          run = 0, last_run = 0;
  bit          prev_wr = 1'b0;

  // Demux model: latches dato into the selected register every clock
  always @(posedge clk) begin
    if (selector < 4'd10) demux[selector] <= dato;
  end

  // Observer: write cycles, pulses and rd_req run lengths
  always @(negedge clk) begin
    if (!$isunknown(selector) && selector != PARK) begin
      wq.push_back({selector, dato});
      if (prev_wr) adjacent++;
      prev_wr = 1'b1;
    end else begin
      prev_wr = 1'b0;
      if (!$isunknown(selector) && dato !== 8'h00) park_bad++;
    end
    if (burst_done === 1'b1) n_done++;
    if (wr_ack === 1'b1) n_ack++;
    if (err_timeout === 1'b1) n_to++;
    if (rd_req === 1'b1) run++;
    else if (run > 0) begin
      last_run = run;
      run = 0;
    end
  end

  // Source port: answers src_lat cycles after rd_req, never answers index src_hang
  initial begin
    int w;
    w = 0;
    rd_valid = 1'b0;
    rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_req === 1'b1 && rd_addr != src_hang) begin
        if (w >= src_lat) begin
          rd_valid = 1'b1;
          rd_data = src_data[rd_addr];
        end
        w++;
      end else begin
        rd_valid = 1'b0;
        w = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic randomize_src();
    for (int i = 0; i < 16; i++) src_data[i] = 8'($urandom);
  endtask

  task automatic burst_model(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      exp_q.push_back({4'(i), src_data[i]});
      exp_regs[i] = src_data[i];
    end
  endtask

  task automatic run_burst(input int max_cyc, output int cyc);
    burst_start = 1'b1;
    cyc = 0;
    while (cyc < max_cyc) begin
      tick();
      cyc++;
      burst_start = 1'b0;
      if (burst_done === 1'b1) break;
    end
  endtask

  task automatic compare_writes(input string tag, input int base);
    check({tag, "_count"}, 32'(wq.size() - base), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      if (base + k < wq.size())
        check($sformatf("%s_w%0d", tag, k), 32'(wq[base + k]), 32'(exp_q[k]));
  endtask

  task automatic compare_regs(input string tag);
    for (int i = 0; i < NREG; i++)
      check($sformatf("%s_r%0d", tag, i), 32'(demux[i]), 32'(exp_regs[i]));
  endtask

  task automatic do_single(input logic [3:0] sel, input logic [7:0] data);
    logic [3:0] es;
    logic [7:0] ed;
    es = (sel <= 4'd9) ? sel : PARK;
    ed = (sel <= 4'd9) ? data : 8'h00;
    wr_sel = sel;
    wr_data = data;
    wr_req = 1'b1;
    tick();
    check("single_ack", 32'(wr_ack), 32'(1));
    check("single_sel", 32'(selector), 32'(es));
    check("single_dato", 32'(dato), 32'(ed));
    check("single_busy", 32'(busy), 32'(1));
    wr_req = 1'b0;
    if (sel < 4'd9) begin
      exp_q.push_back({sel, data});
      exp_regs[sel] = data;
    end
    tick();
    check("single_ack_pulse", 32'(wr_ack), 32'(0));
  endtask

  initial begin
    int base, d_done, d_ack, d_to, d_adj, cyc;
    logic [3:0] s;
    logic [7:0] d;

    reset = 1'b0;
    burst_start = 1'b0;
    wr_req = 1'b1;
    wr_sel = 4'd3;
    wr_data = 8'h77;
    src_lat = 1;
    src_hang = 4'hF;
    for (int i = 0; i < 16; i++) src_data[i] = 8'h00;
    for (int i = 0; i < NREG; i++) exp_regs[i] = 8'h00;

    // Reset held with a pending single write: nothing may leave the block
    repeat (3) begin
      tick();
      check("rst_sel", 32'(selector), 32'(PARK));
      check("rst_dato", 32'(dato), 32'(0));
      check("rst_rd_req", 32'(rd_req), 32'(0));
      check("rst_wr_ack", 32'(wr_ack), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
    end
    check("rst_rd_addr", 32'(rd_addr), 32'(0));
    check("rst_done", 32'(burst_done), 32'(0));
    check("rst_to", 32'(err_timeout), 32'(0));
    wr_req = 1'b0;
    tick();
    reset = 1'b1;
    repeat (2) tick();
    check("idle_busy", 32'(busy), 32'(0));

    // Burst with data 10+idx, source latency 1
    for (int i = 0; i < 16; i++) src_data[i] = 8'h10 + 8'(i);
    src_lat = 1;
    exp_q.delete();
    base = wq.size(); d_done = n_done; d_adj = adjacent;
    run_burst(200, cyc);
    check("t2_done", 32'(burst_done), 32'(1));
    check("t2_cycles", 32'(cyc), 32'(3 * NREG + 1));
    burst_model(0, NREG - 1);
    tick();
    check("t2_done_pulse", 32'(burst_done), 32'(0));
    check("t2_busy_after", 32'(busy), 32'(0));
    tick();
    compare_writes("t2", base);
    check("t2_done_count", 32'(n_done - d_done), 32'(1));
    check("t2_parked_between", 32'(adjacent - d_adj), 32'(0));
    compare_regs("t2");

    // Zero-latency source: 2*NREG+1 cycles start to done
    randomize_src();
    src_lat = 0;
    exp_q.delete();
    base = wq.size();
    run_burst(200, cyc);
    check("z_cycles", 32'(cyc), 32'(2 * NREG + 1));
    burst_model(0, NREG - 1);
    repeat (2) tick();
    compare_writes("z", base);
    compare_regs("z");

    // Single write injected after index 4, wr_req held one cycle past wr_ack
    randomize_src();
    src_lat = int'($urandom_range(0, 2));
    exp_q.delete();
    base = wq.size(); d_ack = n_ack; d_done = n_done;
    burst_start = 1'b1;
    cyc = 0;
    while (cyc < 200) begin
      tick();
      cyc++;
      burst_start = 1'b0;
      if (selector === 4'd4) break;
    end
    check("t3_reach4", 32'(selector), 32'(4));
    wr_sel = 4'd3; wr_data = 8'hAA; wr_req = 1'b1;
    tick();
    check("t3_single_sel", 32'(selector), 32'(3));
    check("t3_single_dato", 32'(dato), 32'(8'hAA));
    check("t3_single_ack", 32'(wr_ack), 32'(1));
    tick();
    check("t3_no_second_ack", 32'(wr_ack), 32'(0));
    check("t3_resume_req", 32'(rd_req), 32'(1));
    check("t3_resume_addr", 32'(rd_addr), 32'(5));
    wr_req = 1'b0;
    cyc = 0;
    while (cyc < 200 && burst_done !== 1'b1) begin
      tick();
      cyc++;
    end
    check("t3_done", 32'(burst_done), 32'(1));
    burst_model(0, 4);
    exp_q.push_back({4'd3, 8'hAA});
    burst_model(5, NREG - 1);
    exp_regs[3] = 8'hAA;
    repeat (2) tick();
    compare_writes("t3", base);
    check("t3_ack_count", 32'(n_ack - d_ack), 32'(1));
    check("t3_done_count", 32'(n_done - d_done), 32'(1));
    compare_regs("t3");

    // Source silent on index 2: abort after 255 cycles of rd_req
    randomize_src();
    src_lat = 0;
    src_hang = 4'd2;
    exp_q.delete();
    base = wq.size(); d_done = n_done; d_to = n_to;
    burst_start = 1'b1;
    cyc = 0;
    while (cyc < 400) begin
      tick();
      cyc++;
      burst_start = 1'b0;
      if (err_timeout === 1'b1) break;
    end
    check("t4_timeout", 32'(err_timeout), 32'(1));
    check("t4_busy", 32'(busy), 32'(0));
    check("t4_rd_req", 32'(rd_req), 32'(0));
    check("t4_sel", 32'(selector), 32'(PARK));
    tick();
    check("t4_to_pulse", 32'(err_timeout), 32'(0));
    check("t4_req_cycles", 32'(last_run), 32'(255));
    burst_model(0, 1);
    tick();
    compare_writes("t4", base);
    check("t4_no_done", 32'(n_done - d_done), 32'(0));
    check("t4_to_count", 32'(n_to - d_to), 32'(1));
    compare_regs("t4");
    src_hang = 4'hF;

    // Idle singles: out-of-range index dropped, others written one edge later
    exp_q.delete();
    base = wq.size();
    do_single(4'd12, 8'h55);
    repeat (6) do_single(4'($urandom_range(0, 15)), 8'($urandom));
    tick();
    compare_writes("t5", base);
    compare_regs("t5");

    // burst_start with wr_req, then reset during the index 5 fetch
    randomize_src();
    src_lat = int'($urandom_range(0, 2));
    s = 4'($urandom_range(0, 8));
    d = 8'($urandom);
    exp_q.delete();
    base = wq.size(); d_done = n_done;
    wr_sel = s; wr_data = d; wr_req = 1'b1; burst_start = 1'b1;
    tick();
    check("t6_single_ack", 32'(wr_ack), 32'(1));
    check("t6_single_sel", 32'(selector), 32'(s));
    wr_req = 1'b0; burst_start = 1'b0;
    exp_q.push_back({s, d});
    exp_regs[s] = d;
    cyc = 0;
    while (cyc < 200) begin
      tick();
      cyc++;
      if (rd_req === 1'b1 && rd_addr === 4'd5) break;
    end
    check("t6_reach5", 32'(rd_addr), 32'(5));
    reset = 1'b0;
    tick();
    check("t6_rst_sel", 32'(selector), 32'(PARK));
    check("t6_rst_dato", 32'(dato), 32'(0));
    check("t6_rst_rd_req", 32'(rd_req), 32'(0));
    check("t6_rst_rd_addr", 32'(rd_addr), 32'(0));
    check("t6_rst_busy", 32'(busy), 32'(0));
    check("t6_rst_ack", 32'(wr_ack), 32'(0));
    check("t6_rst_done", 32'(burst_done), 32'(0));
    check("t6_rst_to", 32'(err_timeout), 32'(0));
    reset = 1'b1;
    repeat (30) tick();
    check("t6_idle_busy", 32'(busy), 32'(0));
    check("t6_idle_req", 32'(rd_req), 32'(0));
    check("t6_no_done", 32'(n_done - d_done), 32'(0));
    burst_model(0, 4);
    compare_writes("t6", base);
    compare_regs("t6");

    // Final random-latency burst after the aborted one
    randomize_src();
    src_lat = int'($urandom_range(0, 3));
    exp_q.delete();
    base = wq.size(); d_done = n_done;
    run_burst(300, cyc);
    check("f_cycles", 32'(cyc), 32'((src_lat + 2) * NREG + 1));
    burst_model(0, NREG - 1);
    repeat (2) tick();
    compare_writes("f", base);
    check("f_done_count", 32'(n_done - d_done), 32'(1));
    compare_regs("f");
    check("park_dato_zero", 32'(park_bad), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
